// File: rtl/draw_scheduler_if.sv
// Purpose: groups the frame/request/done inputs and grant/status outputs of the draw scheduler.
// Latency: none, wires only.
// Backpressure: none; the frame_tick/done pulses and the start pulse are the only handshake.
//
// Signals:
//   frame_tick  1  pulse starting a drawing frame
//   req        12  per-client draw request, latched on an accepted frame_tick
//   done       12  per-client completion pulse
//   start      12  one-hot grant pulse
//   select      4  index of the granted client (pixel mux select)
//   busy        1  scheduler is not idle
//   frame_done  1  pulse when every latched request has been serviced
//   overrun     1  sticky: frame_tick seen while busy
//   timeout_err 1  sticky: a client ran past the wait limit
interface draw_scheduler_if;
  logic        frame_tick;
  logic [11:0] req;
  logic [11:0] done;
  logic [11:0] start;
  logic [3:0]  select;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        timeout_err;

  // Client / frame-source side.
  modport master (
    output frame_tick, req, done,
    input  start, select, busy, frame_done, overrun, timeout_err
  );

  // Scheduler side.
  modport slave (
    input  frame_tick, req, done,
    output start, select, busy, frame_done, overrun, timeout_err
  );
endinterface

// File: rtl/draw_scheduler.sv
// Purpose: grants up to 12 drawing clients in ascending index order once per frame.
// Latency: tick to first start pulse is 1 + (index of first requester) + 1 cycles; one scan cycle per index.
// Backpressure: none; each client holds the grant until its done pulse or until WAIT_LIMIT cycles pass.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  synchronous active-high reset
//   bus    slave modport of draw_scheduler_if (frame_tick/req/done in,
//          start/select/busy/frame_done/overrun/timeout_err out, all registered)
module draw_scheduler #(
  parameter int unsigned WAIT_LIMIT = 19200
) (
  input  logic              clk,
  input  logic              reset,
  draw_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [3:0]  LP_LAST_IDX = 4'd11;
  // Counter value seen in the last allowed WAIT cycle of a grant.
  localparam logic [14:0] LP_CNT_LAST = 15'(WAIT_LIMIT - 1);

  // State and datapath registers.
  state_t      r_state;
  logic [11:0] r_pending;
  logic [3:0]  r_idx;
  logic [14:0] r_cnt;

  // Registered outputs.
  logic [11:0] r_start;
  logic [3:0]  r_select;
  logic        r_busy;
  logic        r_frame_done;
  logic        r_overrun;
  logic        r_timeout;

  // Next-state values.
  state_t      w_state_nxt;
  logic [11:0] w_pending_nxt;
  logic [3:0]  w_idx_nxt;
  logic [14:0] w_cnt_nxt;
  logic [11:0] w_start_nxt;
  logic [3:0]  w_select_nxt;
  logic        w_busy_nxt;
  logic        w_frame_done_nxt;
  logic        w_overrun_nxt;
  logic        w_timeout_nxt;
  logic        w_release;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pending_nxt    = r_pending;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_start_nxt      = '0;
    w_select_nxt     = r_select;
    w_frame_done_nxt = 1'b0;
    w_timeout_nxt    = r_timeout;
    w_release        = 1'b0;
    // A tick outside IDLE is only recorded, never acted upon.
    w_overrun_nxt    = r_overrun | (bus.frame_tick && (r_state != ST_IDLE));

    case (r_state)
      ST_IDLE: begin
        if (bus.frame_tick) begin
          w_pending_nxt = bus.req;
          w_idx_nxt     = '0;
          w_state_nxt   = (bus.req == '0) ? ST_FINISH : ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (r_pending[r_idx]) begin
          // Grant: start pulse and mux select appear together in the first WAIT cycle.
          w_state_nxt         = ST_WAIT;
          w_cnt_nxt           = '0;
          w_select_nxt        = r_idx;
          w_start_nxt[r_idx]  = 1'b1;
        end else if (r_idx == LP_LAST_IDX) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_idx_nxt = r_idx + 4'd1;
        end
      end

      ST_WAIT: begin
        // done wins over the limit when both land in the same cycle.
        if (bus.done[r_idx]) begin
          w_release = 1'b1;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_release     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 15'd1;
        end

        if (w_release) begin
          w_pending_nxt[r_idx] = 1'b0;
          if (r_idx == LP_LAST_IDX) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = r_idx + 4'd1;
          end
        end
      end

      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // FINISH never repeats, so entering it is exactly the single frame_done cycle.
    w_frame_done_nxt = (w_state_nxt == ST_FINISH);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending    <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_start      <= '0;
      r_select     <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_pending    <= w_pending_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_start      <= w_start_nxt;
      r_select     <= w_select_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_overrun    <= w_overrun_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign bus.start       = r_start;
  assign bus.select      = r_select;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_frame_done;
  assign bus.overrun     = r_overrun;
  assign bus.timeout_err = r_timeout;

  // Structural invariants: grant is one-hot and the scan index stays inside the client range.
  a_start_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(r_start));
  a_idx_range:    assert property (@(posedge clk) disable iff (reset) r_idx <= LP_LAST_IDX);

endmodule

// File: tb/tb_draw_scheduler.sv
// Purpose: directed self-checking bench for draw_scheduler with a frame-level reference model.
// Latency: model predicts every registered output for each cycle.
// Backpressure: not applicable; done pulses are scripted per scenario.
module tb_draw_scheduler;

  localparam int WL = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   cmp_en;

  draw_scheduler_if bus ();

  draw_scheduler #(.WAIT_LIMIT(WL)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model. A frame is a walk over the 12 slots: the walk costs one
  // cycle per slot inspected, so the next grant (or the end of the frame) is a
  // known number of cycles ahead of the current cursor.
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_SCAN = 1, M_WAIT = 2, M_FIN = 3;

  int          m_mode;
  int          m_gap;      // scan cycles left before the next event
  int          m_target;   // client to grant after the gap, -1 = frame end
  int          m_idx;
  int          m_cnt;      // completed WAIT cycles of the current grant
  logic [11:0] m_pend;

  logic [11:0] e_start;
  logic [3:0]  e_sel;
  logic        e_busy, e_fd, e_ovr, e_to;

  function automatic int first_pending(logic [11:0] p, int from);
    for (int i = from; i < 12; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic void enter_finish();
    m_mode = M_FIN;
    e_fd   = 1'b1;
  endfunction

  function automatic void plan_from(int p);
    int j;
    if (p > 11) begin
      enter_finish();
    end else begin
      j      = first_pending(m_pend, p);
      m_mode = M_SCAN;
      if (j < 0) begin
        m_gap    = 12 - p;
        m_target = -1;
      end else begin
        m_gap    = j - p + 1;
        m_target = j;
      end
    end
  endfunction

  function automatic void release_client();
    m_pend[m_idx] = 1'b0;
    plan_from(m_idx + 1);
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_mode = M_IDLE; m_pend = '0; m_idx = 0; m_cnt = 0; m_gap = 0; m_target = -1;
      e_start = '0; e_sel = '0; e_busy = 1'b0; e_fd = 1'b0; e_ovr = 1'b0; e_to = 1'b0;
    end else begin
      e_start = '0;
      e_fd    = 1'b0;
      if (bus.frame_tick && m_mode != M_IDLE) e_ovr = 1'b1;
      case (m_mode)
        M_IDLE: if (bus.frame_tick) begin
          m_pend = bus.req;
          if (bus.req == '0) enter_finish();
          else plan_from(0);
        end
        M_SCAN: begin
          m_gap--;
          if (m_gap == 0) begin
            if (m_target < 0) enter_finish();
            else begin
              m_mode  = M_WAIT;
              m_idx   = m_target;
              m_cnt   = 0;
              e_start = 12'h001 << m_target;
              e_sel   = 4'(m_target);
            end
          end
        end
        M_WAIT: begin
          m_cnt++;
          if (bus.done[m_idx]) release_client();
          else if (m_cnt == WL) begin
            e_to = 1'b1;
            release_client();
          end
        end
        default: m_mode = M_IDLE;
      endcase
      e_busy = (m_mode != M_IDLE);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("start",       32'(bus.start),       32'(e_start));
      chk("select",      32'(bus.select),      32'(e_sel));
      chk("busy",        32'(bus.busy),        32'(e_busy));
      chk("frame_done",  32'(bus.frame_done),  32'(e_fd));
      chk("overrun",     32'(bus.overrun),     32'(e_ovr));
      chk("timeout_err", 32'(bus.timeout_err), 32'(e_to));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic t, input logic [11:0] r, input logic [11:0] d, input logic rs);
    bus.frame_tick = t;
    bus.req        = r;
    bus.done       = d;
    rst            = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"},  32'(bus.start),       32'h0);
    chk({tag, "_select"}, 32'(bus.select),      32'h0);
    chk({tag, "_busy"},   32'(bus.busy),        32'h0);
    chk({tag, "_fd"},     32'(bus.frame_done),  32'h0);
    chk({tag, "_ovr"},    32'(bus.overrun),     32'h0);
    chk({tag, "_to"},     32'(bus.timeout_err), 32'h0);
  endtask

  task automatic do_reset();
    drive(1'b0, 12'h0, 12'h0, 1'b1);
    cmp_en = 1'b1;
    check_reset_vals("rst");
    drive(1'b0, 12'h0, 12'h0, 1'b1);
    drive(1'b0, 12'h0, 12'h0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cmp_en  = 1'b0;
    cyc     = 0;

    // Two clients (0 and 2); req noise after the tick must not matter.
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      if (c == 2)  begin chk("s1_start_c0", 32'(bus.start), 32'h001); chk("s1_sel_c0", 32'(bus.select), 32'd0); end
      if (c == 8)  begin chk("s1_start_c2", 32'(bus.start), 32'h004); chk("s1_sel_c2", 32'(bus.select), 32'd2); end
      if (c == 20) chk("s1_frame_done", 32'(bus.frame_done), 32'h1);
      if (c == 21) chk("s1_busy_low", 32'(bus.busy), 32'h0);
      drive(c == 0, (c == 0) ? 12'h005 : 12'hFFF,
            (c == 5) ? 12'h001 : (c == 10) ? 12'h004 : 12'h000, 1'b0);
    end

    // Empty frame, then a tick in the IDLE cycle right after FINISH.
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c == 1) begin chk("s2_fd", 32'(bus.frame_done), 32'h1); chk("s2_busy", 32'(bus.busy), 32'h1); end
      if (c == 2) begin chk("s2_fd_off", 32'(bus.frame_done), 32'h0); chk("s2_sel", 32'(bus.select), 32'h0); end
      if (c == 3) chk("s2_fd_again", 32'(bus.frame_done), 32'h1);
      drive(c == 0 || c == 2, 12'h000, 12'h000, 1'b0);
    end

    // done and the wait limit on the same cycle: done wins.
    do_reset();
    for (int c = 0; c <= 23; c++) begin
      if (c == 10) chk("s3_tie_no_to", 32'(bus.timeout_err), 32'h0);
      if (c == 21) chk("s3_fd", 32'(bus.frame_done), 32'h1);
      drive(c == 0, (c == 0) ? 12'h001 : 12'h000, (c == 9) ? 12'h001 : 12'h000, 1'b0);
    end

    // Client 11 never finishes: 8 WAIT cycles then timeout.
    for (int c = 0; c <= 24; c++) begin
      if (c == 13) begin chk("s3_start11", 32'(bus.start), 32'h800); chk("s3_sel11", 32'(bus.select), 32'd11); end
      if (c == 20) chk("s3_to_pending", 32'(bus.timeout_err), 32'h0);
      if (c == 21) begin chk("s3_to_set", 32'(bus.timeout_err), 32'h1); chk("s3_to_fd", 32'(bus.frame_done), 32'h1); end
      if (c == 22) chk("s3_to_busy", 32'(bus.busy), 32'h0);
      drive(c == 0, (c == 0) ? 12'h800 : 12'h000, 12'h000, 1'b0);
    end

    // Overrun tick while client 3 is granted; a later tick starts a new frame.
    do_reset();
    for (int c = 0; c <= 35; c++) begin
      if (c == 7)  chk("s4_overrun", 32'(bus.overrun), 32'h1);
      if (c == 10) chk("s4_no_relatch", 32'(bus.start), 32'h000);
      if (c == 17) chk("s4_fd", 32'(bus.frame_done), 32'h1);
      if (c == 21) chk("s4_new_frame", 32'(bus.start), 32'h002);
      if (c == 33) chk("s4_ovr_sticky", 32'(bus.overrun), 32'h1);
      drive(c == 0 || c == 6 || c == 18,
            (c == 0) ? 12'h008 : (c == 18) ? 12'h002 : 12'hFFF,
            (c == 8) ? 12'h008 : (c == 22) ? 12'h002 : 12'h000, 1'b0);
    end

    // Spurious done bits while client 8 is granted.
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      if (c == 10) begin chk("s5_start8", 32'(bus.start), 32'h100); chk("s5_sel8", 32'(bus.select), 32'd8); end
      if (c == 13) chk("s5_still_busy", 32'(bus.busy), 32'h1);
      if (c == 17) chk("s5_fd", 32'(bus.frame_done), 32'h1);
      drive(c == 0, (c == 0) ? 12'h100 : 12'h000,
            (c == 11 || c == 12) ? 12'h0FF : (c == 13) ? 12'h100 : 12'h000, 1'b0);
    end

    // Reset in the middle of client 6's WAIT.
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      if (c == 9) chk("s6_sel6", 32'(bus.select), 32'd6);
      if (c == 11) check_reset_vals("s6_midwait");
      if (c == 16) chk("s6_start0", 32'(bus.start), 32'h001);
      if (c == 28) chk("s6_fd", 32'(bus.frame_done), 32'h1);
      drive(c == 0 || c == 14, (c == 0) ? 12'h040 : (c == 14) ? 12'h001 : 12'h000,
            (c == 12) ? 12'h040 : (c == 16) ? 12'h001 : 12'h000, c == 10);
    end

    drive(1'b0, 12'h0, 12'h0, 1'b0);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 The block SHALL have a parameter WAIT_LIMIT, default 19200, giving the maximum cycles granted to one client per frame.
REQ-002 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle pulse marking the start of a drawing frame.
REQ-005 req  input  12  bit i high means client i (i = 0..11) needs to draw this frame; sampled only on an accepted frame_tick.
REQ-006 done  input  12  bit i pulses high when client i has finished drawing.
REQ-007 start  output  12  one-hot, one-cycle pulse telling client i to begin drawing.
REQ-008 select  output  4  index of the granted client; drives the 4-bit select of the pixel mux feeding the VGA adapter.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 frame_done  output  1  one-cycle pulse when every latched request has been serviced.
REQ-011 overrun  output  1  sticky flag: a frame_tick arrived while busy.
REQ-012 timeout_err  output  1  sticky flag: a client exceeded WAIT_LIMIT.

Function
REQ-013 States SHALL be IDLE, SCAN, WAIT and FINISH; all outputs SHALL be registered.
REQ-014 IDLE: on frame_tick, the block SHALL latch req into a 12-bit pending mask, set idx=0 and go to SCAN; if req==0 it SHALL go to FINISH instead.
REQ-015 SCAN: the block SHALL examine one index per cycle; if pending[idx] it SHALL go to WAIT, otherwise it SHALL increment idx.
REQ-016 SCAN with idx==11 and pending[11]==0 SHALL go to FINISH; idx SHALL never exceed 11.
REQ-017 In the first WAIT cycle, start[idx] SHALL be 1 and select SHALL equal idx; start SHALL be 0 in all other cycles.
REQ-018 select SHALL hold idx throughout WAIT, and SHALL keep its last value through SCAN and FINISH; it changes only on entry to WAIT or on reset.
REQ-019 WAIT: done[idx]==1, including in the start cycle, SHALL clear pending[idx]; the block SHALL then go to FINISH if idx==11, else to SCAN with idx+1.
REQ-020 done bits other than done[idx], and all done bits outside WAIT, SHALL be ignored.
REQ-021 A 15-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-022 If the wait counter reaches WAIT_LIMIT-1 without done[idx], the block SHALL set timeout_err, clear pending[idx] and advance exactly as in REQ-019.
REQ-023 If done[idx] and the limit are reached in the same cycle, done SHALL take priority and timeout_err SHALL NOT be set.
REQ-024 FINISH SHALL last one cycle, assert frame_done in that cycle and then return to IDLE.
REQ-025 A frame_tick while busy (SCAN, WAIT or FINISH) SHALL set overrun and SHALL otherwise be ignored; it SHALL NOT relatch req or restart.
REQ-026 A frame_tick in the IDLE cycle that follows FINISH SHALL be accepted normally.
REQ-027 Clients SHALL be serviced strictly in ascending index order, at most once per frame.
REQ-028 Changes on req after the frame_tick SHALL NOT affect the current frame.

Reset
REQ-029 reset==1 SHALL force state IDLE, pending=0, idx=0, select=0, start=0, busy=0, frame_done=0, overrun=0, timeout_err=0 and wait counter=0 on the next edge.
REQ-030 reset SHALL take priority over every other input, including mid-WAIT; no start pulse or frame_done SHALL follow a reset until the next frame_tick.
REQ-031 overrun and timeout_err SHALL clear only on reset.

Verification
REQ-032 req=12'h005, tick at cycle 0 -> start=12'h001 at cycle 2 with select=0; done[0] at cycle 5 -> start=12'h004 at cycle 8 with select=2; done[2] at cycle 10 -> frame_done at FINISH; busy low thereafter.
REQ-033 req=0, tick -> FINISH, then a single frame_done pulse; start stays 0 and select stays 0.
REQ-034 WAIT_LIMIT=8, req=12'h800, done never asserted -> start[11], 8 WAIT cycles, timeout_err=1, frame_done pulse, and busy falls.
REQ-035 Second tick during WAIT on client 3 -> overrun=1, same frame continues, pending unchanged; a later tick accepted in IDLE starts a new frame.
REQ-036 Spurious done=12'h0FF while client 8 is granted -> ignored; done[8] advances the frame.
REQ-037 reset asserted during WAIT on client 6 -> all outputs at reset values the next cycle; no frame_done until a new tick completes a frame.
